// File: rtl/if_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch stage and its buffer.
package if_pkg;

    localparam int unsigned IB_DEPTH_DEFAULT = 8;
    localparam int unsigned INST_BYTES       = 4;
    localparam int unsigned LINE_BYTES       = 8;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } ib_entry_t;

endpackage

// File: rtl/if_fetch_buffer_if.sv
// Icache-facing and decode-facing signals of the fetch stage; slave is the fetch stage.
interface if_fetch_buffer_if #(
    parameter int unsigned IB_DEPTH = if_pkg::IB_DEPTH_DEFAULT
);

    logic [63:0]                      Icache_data_out;
    logic                             Icache_valid_out;
    logic                             redirect_en;
    logic [63:0]                      redirect_pc;
    logic [1:0]                       deq_count;
    logic [63:0]                      proc2Icache_addr;
    logic [1:0][31:0]                 ib_inst;
    logic [1:0][63:0]                 ib_pc;
    logic [1:0]                       ib_valid;
    logic [$clog2(IB_DEPTH+1)-1:0]    ib_count;

    modport master (
        output Icache_data_out, Icache_valid_out, redirect_en, redirect_pc, deq_count,
        input  proc2Icache_addr, ib_inst, ib_pc, ib_valid, ib_count
    );

    modport slave (
        input  Icache_data_out, Icache_valid_out, redirect_en, redirect_pc, deq_count,
        output proc2Icache_addr, ib_inst, ib_pc, ib_valid, ib_count
    );

endinterface

// File: rtl/if_fetch_buffer_ib_fifo.sv
// Dual-push / dual-pop circular instruction buffer with flush.
module ib_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = IB_DEPTH_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [1:0]                    push_n,
    input  ib_entry_t                     push_entry [2],
    input  logic [1:0]                    pop_n,
    output ib_entry_t                     head_entry [2],
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    ib_entry_t       mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [1:0]      pop_c;

    // Never pop more than is held; count can only be below pop_n when it is 0 or 1.
    always_comb begin
        pop_c = pop_n;
        if (CW'(pop_n) > count) pop_c = count[1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop_c);
            tail  <= tail + PW'(push_n);
            count <= count + CW'(push_n) - CW'(pop_c);
        end
    end

    always_ff @(posedge clock) begin
        if (!flush) begin
            if (push_n != 2'd0) mem[tail]          <= push_entry[0];
            if (push_n == 2'd2) mem[tail + PW'(1)] <= push_entry[1];
        end
    end

    assign head_entry[0] = mem[head];
    assign head_entry[1] = mem[head + PW'(1)];

endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch stage: owns fetch_pc, splits icache lines into instructions and feeds the buffer.
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned IB_DEPTH = IB_DEPTH_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    if_fetch_buffer_if.slave fb
);

    localparam int unsigned CW = $clog2(IB_DEPTH+1);

    logic [63:0]    fetch_pc;
    logic [1:0]     nw;
    logic [1:0]     push_n;
    logic [1:0]     pop_n;
    logic           push_ok;
    logic [CW-1:0]  count;
    logic [CW-1:0]  free;
    ib_entry_t      push_entry [2];
    ib_entry_t      head_entry [2];

    // Room is judged against the pre-pop count, so a pop never makes space in the same cycle.
    always_comb begin
        nw      = fetch_pc[2] ? 2'd1 : 2'd2;
        free    = CW'(IB_DEPTH) - count;
        push_ok = fb.Icache_valid_out && !fb.redirect_en && (free >= CW'(nw));
        push_n  = push_ok ? nw : 2'd0;
        pop_n   = fb.redirect_en ? 2'd0 : fb.deq_count;

        push_entry[0] = '{inst: fb.Icache_data_out[31:0], pc: fetch_pc};
        if (fetch_pc[2]) push_entry[0].inst = fb.Icache_data_out[63:32];
        push_entry[1] = '{inst: fb.Icache_data_out[63:32], pc: fetch_pc + 64'(INST_BYTES)};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= {RESET_PC[63:2], 2'b00};
        end else if (fb.redirect_en) begin
            fetch_pc <= {fb.redirect_pc[63:2], 2'b00};
        end else if (push_ok) begin
            fetch_pc <= fetch_pc + 64'(INST_BYTES) * 64'(nw);
        end
    end

    ib_fifo #(
        .DEPTH(IB_DEPTH)
    ) u_ib_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (fb.redirect_en),
        .push_n     (push_n),
        .push_entry (push_entry),
        .pop_n      (pop_n),
        .head_entry (head_entry),
        .count      (count)
    );

    assign fb.proc2Icache_addr = fetch_pc & ~64'(LINE_BYTES - 1);
    assign fb.ib_count         = count;

    always_comb begin
        fb.ib_valid = '0;
        fb.ib_inst  = '0;
        fb.ib_pc    = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            fb.ib_valid[i] = (count > CW'(i));
            if (fb.ib_valid[i]) begin
                fb.ib_inst[i] = head_entry[i].inst;
                fb.ib_pc[i]   = head_entry[i].pc;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Scoreboard bench for if_fetch_buffer: expected entries are queued as lines are fed in.
module tb_if_fetch_buffer;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    logic clock;
    logic reset;

    if_fetch_buffer_if #(.IB_DEPTH(8)) fb ();

    if_fetch_buffer #(
        .RESET_PC (64'h1004),
        .IB_DEPTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .fb    (fb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t        sb [$];
    logic [63:0] m_pc;
    int unsigned n_cmp;
    int unsigned n_err;

    function automatic logic [31:0] inst_for(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [63:0] line_for(input logic [63:0] line);
        return {inst_for(line + 64'd4), inst_for(line)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, compare visible outputs to the model, advance the model.
    task automatic step(input bit valid, input bit redir, input logic [63:0] rpc,
                        input int unsigned deq);
        int unsigned nw;
        int unsigned pops;
        bit          room;
        exp_t        e;
        fb.Icache_valid_out = valid;
        fb.Icache_data_out  = valid ? line_for({m_pc[63:3], 3'b000}) : 64'hDEAD_BEEF_DEAD_BEEF;
        fb.redirect_en      = redir;
        fb.redirect_pc      = rpc;
        fb.deq_count        = 2'(deq);

        check("addr", fb.proc2Icache_addr, {m_pc[63:3], 3'b000});
        check("count", 64'(fb.ib_count), 64'(sb.size()));
        for (int s = 0; s < 2; s++) begin
            if (sb.size() > s) begin
                check("valid", 64'(fb.ib_valid[s]), 64'd1);
                check("pc", fb.ib_pc[s], sb[s].pc);
                check("inst", 64'(fb.ib_inst[s]), 64'(sb[s].inst));
            end else begin
                check("valid", 64'(fb.ib_valid[s]), 64'd0);
                check("pc_zero", fb.ib_pc[s], 64'd0);
                check("inst_zero", 64'(fb.ib_inst[s]), 64'd0);
            end
        end

        if (redir) begin
            sb.delete();
            m_pc = {rpc[63:2], 2'b00};
        end else begin
            nw   = m_pc[2] ? 1 : 2;
            room = (8 - sb.size()) >= nw;
            pops = (deq < sb.size()) ? deq : sb.size();
            repeat (pops) void'(sb.pop_front());
            if (valid && room) begin
                for (int unsigned w = 0; w < nw; w++) begin
                    e.pc   = m_pc + 64'(4 * w);
                    e.inst = inst_for(e.pc);
                    sb.push_back(e);
                end
                m_pc = m_pc + 64'(4 * nw);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        fb.Icache_valid_out = 1'b0;
        fb.Icache_data_out  = '0;
        fb.redirect_en      = 1'b0;
        fb.redirect_pc      = '0;
        fb.deq_count        = '0;
        m_pc = 64'h1004;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state and odd-word first fetch
        check("rst_addr", fb.proc2Icache_addr, 64'h1000);
        check("rst_valid", 64'(fb.ib_valid), 64'd0);
        step(1, 0, 0, 0);
        check("first_pc", fb.ib_pc[0], 64'h1004);
        check("first_count", 64'(fb.ib_count), 64'd1);
        check("first_addr", fb.proc2Icache_addr, 64'h1008);

        // Aligned streaming at 2 in / 2 out
        step(0, 1, 64'h0, 0);
        step(1, 0, 0, 2);
        check("stream_count", 64'(fb.ib_count), 64'd2);
        repeat (8) step(1, 0, 0, 2);
        check("stream_steady", 64'(fb.ib_count), 64'd2);

        // Fill to full, then back-pressure
        step(0, 1, 64'h0, 0);
        repeat (4) step(1, 0, 0, 0);
        check("full_count", 64'(fb.ib_count), 64'd8);
        check("full_addr", fb.proc2Icache_addr, 64'h20);
        step(1, 0, 0, 1);
        check("pop1_count", 64'(fb.ib_count), 64'd7);
        check("pop1_addr", fb.proc2Icache_addr, 64'h20);
        step(1, 0, 0, 1);
        check("pop2_count", 64'(fb.ib_count), 64'd6);
        step(1, 0, 0, 0);
        check("unblock_addr", fb.proc2Icache_addr, 64'h28);
        check("unblock_count", 64'(fb.ib_count), 64'd8);

        // Wrap-around: fill 7, drain 7, push across index 7->0
        step(0, 1, 64'h104, 0);
        repeat (4) step(1, 0, 0, 0);
        check("wrap_fill", 64'(fb.ib_count), 64'd7);
        repeat (3) step(0, 0, 0, 2);
        step(0, 0, 0, 1);
        check("wrap_empty", 64'(fb.ib_count), 64'd0);
        repeat (2) step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 2);

        // Redirect while full with a hit present
        step(0, 1, 64'h0, 0);
        repeat (4) step(1, 0, 0, 0);
        step(1, 1, 64'h2006, 2);
        check("redir_count", 64'(fb.ib_count), 64'd0);
        check("redir_addr", fb.proc2Icache_addr, 64'h2000);
        step(1, 0, 0, 0);
        check("redir_word_pc", fb.ib_pc[0], 64'h2004);
        check("redir_word_cnt", 64'(fb.ib_count), 64'd1);

        // Asynchronous reset mid-cycle with five entries held
        step(0, 1, 64'h4, 0);
        repeat (3) step(1, 0, 0, 0);
        check("pre_arst_count", 64'(fb.ib_count), 64'd5);
        fb.Icache_valid_out = 1'b0;
        fb.deq_count        = '0;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(fb.ib_valid), 64'd0);
        check("arst_count", 64'(fb.ib_count), 64'd0);
        check("arst_pc0", fb.ib_pc[0], 64'd0);
        check("arst_pc1", fb.ib_pc[1], 64'd0);
        check("arst_inst", 64'(fb.ib_inst), 64'd0);
        check("arst_addr", fb.proc2Icache_addr, 64'h1000);
        sb.delete();
        m_pc = 64'h1004;
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 0, 2);
        check("empty_pop", 64'(fb.ib_count), 64'd0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_buffer.md
# if_fetch_buffer

Instruction fetch stage with its own instruction buffer, sitting directly downstream of `icache`. It holds the fetch PC and drives `proc2Icache_addr`. On each `Icache_valid_out` hit it splits the 64-bit line into 32-bit Alpha instructions and pushes them, tagged with their PC, into a circular buffer. Decode/dispatch pops up to two instructions per cycle, and a redirect from branch resolution flushes the buffer and restarts fetch.

## Interface
- `RESET_PC`, default 64'h0: fetch PC after reset; bits [1:0] ignored.
- `IB_DEPTH`, default 8: buffer entries; power of two, at least 4.
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Icache_data_out`  in  64  line for `proc2Icache_addr`.
- `Icache_valid_out`  in  1  `Icache_data_out` is valid this cycle.
- `redirect_en`  in  1  flush and restart fetch.
- `redirect_pc`  in  64  restart PC; bits [1:0] forced to 0.
- `deq_count`  in  2  instructions consumed this cycle (0–2).
- `proc2Icache_addr`  out  64  `{fetch_pc[63:3], 3'b0}`.
- `ib_inst`  out  2x32  oldest two instructions; slot 0 is oldest.
- `ib_pc`  out  2x64  PCs of `ib_inst`.
- `ib_valid`  out  2  slot-valid bits.
- `ib_count`  out  $clog2(IB_DEPTH+1)  occupied entries.

## Operation
- State:
  - `fetch_pc` (64 bits);
  - circular buffer of {inst[31:0], pc[63:0]};
  - `head`, `tail` pointers mod IB_DEPTH;
  - `count`.
- Words to push, `nw`:
  - 2 if `fetch_pc[2]==0`: first push `Icache_data_out[31:0]` at PC `fetch_pc`, then `[63:32]` at `fetch_pc+4`.
  - 1 if `fetch_pc[2]==1`: push only `[63:32]` at `fetch_pc`.
- Push condition: `Icache_valid_out && !redirect_en && (IB_DEPTH - count) >= nw`.
  - Free space is computed from `count` before same-cycle dequeue; a pop does not create room in the same cycle.
- On push: `fetch_pc <= fetch_pc + 4*nw`, modulo 2^64.
  - Line-aligned PC advances 8, odd-word PC advances 4.
- No push (miss, full, or insufficient room): `fetch_pc` holds and `proc2Icache_addr` is re-presented.
- Dequeue:
  - `head` advances by `min(deq_count, count)`; `deq_count` is clamped, never underflows.
  - Push and pop in the same cycle are both honoured: `count <= count + pushed - popped`.
- Redirect, highest priority:
  - `head`, `tail` and `count` are cleared, and `deq_count` is ignored.
  - `fetch_pc <= {redirect_pc[63:2], 2'b00}`.
  - No push that cycle, even if `Icache_valid_out` is high.
- Outputs:
  - `ib_valid[i] = (count > i)`.
  - `ib_inst[i]` and `ib_pc[i]` are zero when `ib_valid[i]==0`.
- Pointer wrap: `tail + 1` and `head + 1` wrap mod IB_DEPTH; the two entries of a 2-word push may straddle the wrap.

## Timing
- `proc2Icache_addr` is a combinational function of `fetch_pc` register only; it has no path from `Icache_*` inputs.
- The icache lookup is same-cycle: a hit in cycle N is written at the edge ending N, and instructions appear on `ib_*` in cycle N+1.
- Redirect asserted in cycle N:
  - `ib_valid==0` in N+1;
  - new address presented in N+1;
  - earliest new instructions visible in N+2.
- Reset, asynchronous, any time including mid-push:
  - `fetch_pc = {RESET_PC[63:2], 2'b00}`;
  - `count = 0`, `head = 0`, `tail = 0`;
  - `ib_valid = 0`, `ib_inst = 0`, `ib_pc = 0`, `ib_count = 0`.
- Sustained throughput is 2 instructions/cycle on aligned hits with 2 pops/cycle, as long as `count <= IB_DEPTH-2`.

## Structure
- Shared package `if_pkg`:
  - `IB_DEPTH` default;
  - `typedef struct packed { logic [31:0] inst; logic [63:0] pc; } ib_entry_t`;
  - `INST_BYTES = 4`;
  - `LINE_BYTES = 8`.
- Sub-module `ib_fifo`:
  - dual-push / dual-pop circular buffer: `push_n[1:0]`, `push_entry[2]`, `pop_n[1:0]`, `flush`;
  - outputs `head_entry[2]`, `count`.
- `if_fetch_buffer` holds `fetch_pc`, push/redirect logic, and output zeroing.

## Test plan
- Reset with `RESET_PC=64'h1004`, then hold `reset` low:
  - `proc2Icache_addr==64'h1000` and `ib_valid==0`.
  - On the first hit, only `[63:32]` is pushed with `pc=64'h1004`, and `fetch_pc` becomes `64'h1008`.
- Aligned streaming, PC 0, always hit, `deq_count=2`:
  - `ib_pc` sequence 0/4, 8/C, 10/14, …
  - `ib_count` steady at 2, no bubbles after cycle 1.
- Full buffer: always hit, `deq_count=0`:
  - `ib_count` reaches 8 after 4 pushes.
  - `proc2Icache_addr` then holds `64'h20`.
  - One pop (`deq_count=1`, count 7) still blocks the push; a second pop unblocks it.
- Wrap-around: fill 7, pop 7, then push:
  - entries straddle index 7→0 and emerge in PC order.
- Redirect while full and `Icache_valid_out=1`, `redirect_pc=64'h2006`:
  - next cycle `ib_count==0` and `proc2Icache_addr==64'h2000`;
  - then one word with `pc=64'h2004`.
- Asynchronous reset asserted mid-cycle with `count==5`:
  - outputs clear immediately without a clock edge;
  - `deq_count=2` while empty leaves `count` at 0.
